ova_gray_dec: RTL
=================

OVA_GRAY_DEC -- requirements
Module: ova_gray_dec

Interface
REQ-001 The block SHALL have parameter IMG_W, default 640, meaning input pixels per line.
REQ-002 The block SHALL have parameter IMG_H, default 480, meaning input lines per frame.
REQ-003 The block SHALL have parameter DEC_X, default 2, meaning the horizontal keep interval (keep every DEC_X-th pixel, starting at column 0).
REQ-004 The block SHALL have parameter DEC_Y, default 2, meaning the vertical keep interval (keep every DEC_Y-th line, starting at row 0).
REQ-005 The block SHALL have parameter FIFO_DEPTH, default 8, meaning output FIFO entries (power of 2).
REQ-006 The block SHALL use one clock and a synchronous, active-high reset.
REQ-007 clk  input  1  system clock; all logic on its rising edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 i_data  input  16  RGB565 pixel from the camera read stage.
REQ-010 i_data_vld  input  1  i_data valid for one cycle; no backpressure.
REQ-011 i_frame_start  input  1  one-cycle pulse before the first pixel of a frame.
REQ-012 o_pix  output  8  grayscale pixel.
REQ-013 o_pix_vld  output  1  o_pix valid.
REQ-014 i_pix_rdy  input  1  consumer ready; a transfer occurs when o_pix_vld and i_pix_rdy are both high.
REQ-015 o_pix_sof  output  1  o_pix is the first kept pixel of a frame.
REQ-016 o_pix_eol  output  1  o_pix is the last kept pixel of a kept line.
REQ-017 o_frame_done  output  1  one-cycle pulse when the frame's last input pixel is consumed.
REQ-018 o_overflow  output  1  sticky flag: a kept pixel was dropped because the FIFO was full.

Function
REQ-019 The FSM SHALL have states IDLE, ACTIVE; IDLE->ACTIVE on i_frame_start; ACTIVE->IDLE on the cycle after the input pixel at (row IMG_H-1, col IMG_W-1).
REQ-020 In IDLE, i_data_vld SHALL be ignored (no counter change, no FIFO write).
REQ-021 i_frame_start in ACTIVE SHALL clear col/row counters and remain in ACTIVE; pixels already in the pipeline or FIFO SHALL still be delivered.
REQ-022 col SHALL increment on each accepted i_data_vld and wrap from IMG_W-1 to 0 while incrementing row; row SHALL wrap to 0 at frame end.
REQ-023 Modulo counters cx (0..DEC_X-1) and cy (0..DEC_Y-1) SHALL track col/row; a pixel is kept iff cx==0 and cy==0; cx SHALL reset to 0 at line wrap.
REQ-024 Expansion: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
REQ-025 Gray SHALL be Y=(77*R8+150*G8+29*B8)>>8, computed in 16-bit unsigned with no overflow (max 65280), truncated, no rounding.
REQ-026 Conversion SHALL be a 2-stage pipeline: a kept pixel sampled at cycle N SHALL be written to the FIFO at cycle N+2.
REQ-027 The FIFO SHALL be first-word-fall-through; each entry SHALL hold {sof, eol, Y}; with the FIFO empty and i_pix_rdy high, o_pix_vld SHALL assert at cycle N+2 relative to input sample N.
REQ-028 sof SHALL tag the kept pixel at row 0/col 0; eol SHALL tag the kept pixel with the largest col<IMG_W that has cx==0.
REQ-029 o_pix, o_pix_sof, o_pix_eol SHALL hold stable while o_pix_vld is high and i_pix_rdy is low.
REQ-030 A FIFO write while full with no simultaneous read SHALL drop the pixel and set o_overflow; a simultaneous read and write when full SHALL succeed.
REQ-031 o_overflow SHALL remain set until i_frame_start or rst.
REQ-032 o_frame_done SHALL pulse at cycle N+1 after the final input pixel at cycle N, independent of FIFO drain.
REQ-033 Output count per frame SHALL be ceil(IMG_W/DEC_X)*ceil(IMG_H/DEC_Y) when no overflow occurs.

Reset
REQ-034 rst SHALL force state IDLE, clear counters, pipeline valids, and FIFO pointers, and drive o_pix=0, o_pix_vld=0, o_pix_sof=0, o_pix_eol=0, o_frame_done=0, o_overflow=0 on the next edge.
REQ-035 rst asserted mid-frame SHALL discard all in-flight and buffered pixels; no output SHALL appear until a new i_frame_start.

Verification
REQ-036 Colour check: i_frame_start, then 16'hFFFF, 16'hF800, 16'h07E0, 16'h001F at DEC_X=DEC_Y=1 -> o_pix 255, 76, 149, 28.
REQ-037 Decimation: IMG_W=4, IMG_H=4, DEC=2, pixel value = index -> 4 outputs from (0,0), (0,2), (2,0), (2,2); sof on 1st output; eol on 2nd and 4th; o_frame_done 1 cycle after the 16th input.
REQ-038 Backpressure: FIFO_DEPTH=4, i_pix_rdy=0, 6 kept pixels -> 4 stored, o_overflow=1; raise i_pix_rdy -> first 4 delivered in order; next i_frame_start clears o_overflow.
REQ-039 Full-with-read: FIFO full, i_pix_rdy=1 on the write cycle -> no drop, o_overflow stays 0.
REQ-040 Reset mid-frame: rst after 5 pixels -> o_pix_vld=0 next cycle; pixels before the next i_frame_start produce no output.
REQ-041 IDLE: i_data_vld pulses with no i_frame_start -> no o_pix_vld, no o_frame_done.

Source files
------------

// File: rtl/ova_gray_dec_if.sv
// Pixel bus of ova_gray_dec: RGB565 pixels pushed in from the camera read stage,
// grayscale pixels with frame/line tags handed to a consumer.
interface ova_gray_dec_if;
    // Input side has no backpressure: a pixel is taken on every edge where
    // i_data_vld is high. Output side transfers on an edge with o_pix_vld &&
    // i_pix_rdy; while o_pix_vld && !i_pix_rdy the payload and tags hold.
    logic [15:0] i_data;
    logic        i_data_vld;
    logic        i_frame_start;
    logic [7:0]  o_pix;
    logic        o_pix_vld;
    logic        i_pix_rdy;
    logic        o_pix_sof;
    logic        o_pix_eol;
    logic        o_frame_done;
    logic        o_overflow;

    modport master (
        output i_data, i_data_vld, i_frame_start, i_pix_rdy,
        input  o_pix, o_pix_vld, o_pix_sof, o_pix_eol, o_frame_done, o_overflow
    );

    modport slave (
        input  i_data, i_data_vld, i_frame_start, i_pix_rdy,
        output o_pix, o_pix_vld, o_pix_sof, o_pix_eol, o_frame_done, o_overflow
    );
endinterface

// File: rtl/ova_gray_dec.sv
// Decimating RGB565-to-grayscale converter: keeps every DEC_X-th pixel of every
// DEC_Y-th line, converts it in a 2-stage pipeline and buffers it in an FWFT FIFO.
module ova_gray_dec #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int DEC_X      = 2,
    parameter int DEC_Y      = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    ova_gray_dec_if.slave bus,
    output logic          dbg_state
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int XW = (DEC_X > 1) ? $clog2(DEC_X) : 1;
    localparam int YW = (DEC_Y > 1) ? $clog2(DEC_Y) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [XW-1:0] CX_LAST  = XW'(DEC_X - 1);
    localparam logic [YW-1:0] CY_LAST  = YW'(DEC_Y - 1);
    // Rightmost column that lands on the horizontal keep grid.
    localparam logic [CW-1:0] EOL_COL  = CW'(((IMG_W - 1) / DEC_X) * DEC_X);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic          accept, keep, last_pix, pix_sof, pix_eol;
    logic [7:0]    r8, g8, b8;

    logic          s1_vld, s1_last, s1_sof, s1_eol;
    logic [15:0]   s1_pr, s1_pg, s1_pb;
    logic          s2_vld, s2_sof, s2_eol;
    logic [7:0]    s2_y;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [9:0]    head;
    logic          empty, full, rd_en, wr_en, drop;
    logic          overflow_q, frame_done_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.i_frame_start) state_nxt = ACTIVE;
            ACTIVE:  if (!bus.i_frame_start && last_pix) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A frame-start pulse wins over a coincident data strobe.
    always_comb begin
        dbg_state = (state == ACTIVE);
        accept    = (state == ACTIVE) && bus.i_data_vld && !bus.i_frame_start;
        keep      = (cx == '0) && (cy == '0);
        last_pix  = accept && (col == COL_LAST) && (row == ROW_LAST);
        pix_sof   = (col == '0) && (row == '0);
        pix_eol   = (col == EOL_COL);
    end

    always_ff @(posedge clk) begin
        if (rst || bus.i_frame_start) begin
            col <= '0;
            row <= '0;
            cx  <= '0;
            cy  <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                cx  <= '0;
                if (row == ROW_LAST) begin
                    row <= '0;
                    cy  <= '0;
                end else begin
                    row <= row + 1'b1;
                    cy  <= (cy == CY_LAST) ? '0 : cy + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
                cx  <= (cx == CX_LAST) ? '0 : cx + 1'b1;
            end
        end
    end

    assign r8 = {bus.i_data[15:11], bus.i_data[15:13]};
    assign g8 = {bus.i_data[10:5],  bus.i_data[10:9]};
    assign b8 = {bus.i_data[4:0],   bus.i_data[4:2]};

    // Stage 1 weights the channels, stage 2 sums; the 16-bit sum never exceeds 65280.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_last <= 1'b0;
            s2_vld <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            s1_vld <= accept && keep;
            s1_last <= last_pix;
            s2_vld <= s1_vld;
            frame_done_q <= s1_last;
        end
        s1_pr  <= 16'd77  * {8'd0, r8};
        s1_pg  <= 16'd150 * {8'd0, g8};
        s1_pb  <= 16'd29  * {8'd0, b8};
        s1_sof <= pix_sof;
        s1_eol <= pix_eol;
        s2_y   <= 8'((s1_pr + s1_pg + s1_pb) >> 8);
        s2_sof <= s1_sof;
        s2_eol <= s1_eol;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en = !empty && bus.i_pix_rdy;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign wr_en = s2_vld && (!full || rd_en);
    assign drop  = s2_vld && full && !rd_en;
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
        if (wr_en) mem[wr_ptr[AW-1:0]] <= {s2_sof, s2_eol, s2_y};
    end

    always_ff @(posedge clk) begin
        if (rst || bus.i_frame_start) overflow_q <= 1'b0;
        else if (drop)                overflow_q <= 1'b1;
    end

    assign bus.o_pix        = empty ? 8'd0 : head[7:0];
    assign bus.o_pix_vld    = !empty;
    assign bus.o_pix_sof    = !empty && head[9];
    assign bus.o_pix_eol    = !empty && head[8];
    assign bus.o_frame_done = frame_done_q;
    assign bus.o_overflow   = overflow_q;
endmodule
